// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the egg timer: state encoding, digit type,
// and the MM:SS increment/decrement arithmetic.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  typedef struct packed {
    bcd_t m_tens;
    bcd_t m_ones;
    bcd_t s_tens;
    bcd_t s_ones;
  } mmss_t;

  function automatic logic is_zero(input mmss_t t);
    return (t == '0);
  endfunction

  // Seconds wrap 59 -> 00 without touching the minutes.
  function automatic mmss_t inc_sec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.s_ones == DIGIT_MAX) begin
      r.s_ones = 4'd0;
      r.s_tens = (t.s_tens == SEC_TENS_MAX) ? 4'd0 : t.s_tens + 4'd1;
    end else begin
      r.s_ones = t.s_ones + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t inc_min(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.m_ones == DIGIT_MAX) begin
      r.m_ones = 4'd0;
      r.m_tens = (t.m_tens == DIGIT_MAX) ? 4'd0 : t.m_tens + 4'd1;
    end else begin
      r.m_ones = t.m_ones + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t dec_time(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.s_ones != 4'd0) begin
      r.s_ones = t.s_ones - 4'd1;
    end else if (t.s_tens != 4'd0) begin
      r.s_ones = DIGIT_MAX;
      r.s_tens = t.s_tens - 4'd1;
    end else if ((t.m_ones != 4'd0) || (t.m_tens != 4'd0)) begin
      r.s_ones = DIGIT_MAX;
      r.s_tens = SEC_TENS_MAX;
      if (t.m_ones != 4'd0) begin
        r.m_ones = t.m_ones - 4'd1;
      end else begin
        r.m_ones = DIGIT_MAX;
        r.m_tens = t.m_tens - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick on the
// terminal count. clr wins over en and returns the count to zero.
module tick_gen #(
  parameter int unsigned DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/egg_timer_core.sv
// BCD MM:SS countdown core: button loading, 1 Hz countdown, pause/resume and
// a self-clearing alarm with a 2 Hz blink. Feeds digit inputs v0..v7.
module egg_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       add_min,
  input  logic       add_sec,
  input  logic       clear,
  output logic [3:0] v0,
  output logic [3:0] v1,
  output logic [3:0] v2,
  output logic [3:0] v3,
  output logic [3:0] v4,
  output logic [3:0] v5,
  output logic [3:0] v6,
  output logic [3:0] v7,
  output logic       running,
  output logic       alarm,
  output logic       blink
);

  localparam int unsigned BLINK_DIV = (CLK_HZ / 4 < 1) ? 1 : CLK_HZ / 4;
  localparam int unsigned BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam int unsigned AW        = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  state_e        state_q, state_d;
  mmss_t         time_q, time_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;

  logic presc_en, presc_clr, tick;
  logic any_btn;

  assign any_btn = start_stop | add_min | add_sec | clear;

  // Prescaler control is kept apart from the FSM so tick never feeds back into its own enable.
  always_comb begin
    presc_en  = 1'b0;
    presc_clr = 1'b0;
    if (clear) begin
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE:    presc_clr = start_stop;
        RUN:     presc_en  = ~start_stop;
        ALARM: begin
          presc_clr = any_btn;
          presc_en  = ~any_btn;
        end
        default: ;
      endcase
    end
  end

  tick_gen #(
    .DIV (CLK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    alarm_cnt_d = alarm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    if (clear) begin
      state_d = IDLE;
      time_d  = '0;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (start_stop) begin
            if (state_q == PAUSE || !is_zero(time_q)) state_d = RUN;
          end else if (add_min) begin
            time_d = inc_min(time_q);
          end else if (add_sec) begin
            time_d = inc_sec(time_q);
          end
        end
        RUN: begin
          if (start_stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            time_d = dec_time(time_q);
            if (is_zero(time_d)) state_d = ALARM;
          end
        end
        ALARM: begin
          if (any_btn) begin
            state_d = IDLE;
            time_d  = '0;
          end else if (tick) begin
            if (alarm_cnt_q == ALARM_LAST) state_d = IDLE;
            else                           alarm_cnt_d = alarm_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Alarm bookkeeping restarts on entry; blink starts high and toggles every BLINK_DIV cycles.
    if (state_d == ALARM) begin
      if (state_q != ALARM) begin
        blink_d     = 1'b1;
        blink_cnt_d = '0;
        alarm_cnt_d = '0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
      alarm_cnt_d = '0;
    end

    running_d = (state_d == RUN);
    alarm_d   = (state_d == ALARM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      time_q      <= '0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign v0      = time_q.s_ones;
  assign v1      = time_q.s_tens;
  assign v2      = time_q.m_ones;
  assign v3      = time_q.m_tens;
  assign v4      = 4'd0;
  assign v5      = 4'd0;
  assign v6      = 4'd0;
  assign v7      = 4'd0;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign blink   = blink_q;

endmodule
